run_stuff_tx: RTL

- Serial transmitter that produces the single-bit `w` stream consumed by the run-length detector FSM (4 consecutive 0s or 4 consecutive 1s asserts z).
- Accepts a parallel word over a valid/ready handshake and frames it as: start bit, bit-stuffed data sent LSB first, then a delimiter run of ones.
- Bit stuffing guarantees the data portion never contains RUN_LEN identical consecutive bits. The only detector hits are therefore the delimiter (run of 1s) and idle (run of 0s).

---
 rtl/run_stuff_pkg.sv | 17 +
 rtl/run_tracker.sv | 54 +++++
 rtl/run_stuff_tx.sv | 131 +++++++++++++
 3 files changed

// File: rtl/run_stuff_pkg.sv
// Shared types and defaults for the bit-stuffing serial transmitter and its
// run-length tracker.
package run_stuff_pkg;

  localparam int unsigned DEF_DATA_W  = 8;
  localparam int unsigned DEF_RUN_LEN = 4;
  localparam int unsigned RUN_CNT_W   = $clog2(DEF_RUN_LEN + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SOF   = 3'd1,
    DATA  = 3'd2,
    STUFF = 3'd3,
    DELIM = 3'd4
  } state_t;

endpackage

// File: rtl/run_tracker.sv
// Tracks the last emitted bit and the length of its run (saturating); flags
// when the next bit must be a stuff bit.
module run_tracker
  import run_stuff_pkg::*;
#(
  parameter int unsigned RUN_LEN = DEF_RUN_LEN
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         emit_en,
  input  logic                         emit_bit,
  input  logic                         load_start,
  output logic                         last_bit,
  output logic [$clog2(RUN_LEN+1)-1:0] run_cnt,
  output logic                         need_stuff
);

  localparam int unsigned CNT_W = $clog2(RUN_LEN + 1);

  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A start bit always opens a fresh run of ones.
  always_comb begin
    last_d = last_q;
    cnt_d  = cnt_q;
    if (load_start) begin
      last_d = 1'b1;
      cnt_d  = CNT_W'(1);
    end else if (emit_en) begin
      if (emit_bit == last_q) begin
        if (cnt_q != CNT_W'(RUN_LEN)) cnt_d = cnt_q + CNT_W'(1);
      end else begin
        last_d = emit_bit;
        cnt_d  = CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      last_q <= 1'b0;
      cnt_q  <= CNT_W'(RUN_LEN);
    end else begin
      last_q <= last_d;
      cnt_q  <= cnt_d;
    end
  end

  assign last_bit   = last_q;
  assign run_cnt    = cnt_q;
  assign need_stuff = (cnt_q == CNT_W'(RUN_LEN - 1));

endmodule

// File: rtl/run_stuff_tx.sv
// Framing serial transmitter: start bit, bit-stuffed LSB-first payload, then a
// delimiter of RUN_LEN ones; w is registered together with the state.
module run_stuff_tx
  import run_stuff_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned RUN_LEN = DEF_RUN_LEN
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              w,
  output logic              stuffing,
  output logic              delim,
  output logic              busy,
  output logic [2:0]        state
);

  localparam int unsigned IDX_W = $clog2(DATA_W + 1);
  localparam int unsigned CNT_W = $clog2(RUN_LEN + 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  dcnt_q, dcnt_d;
  logic              w_q, w_d;
  logic              stuffing_q, stuffing_d;
  logic              delim_q, delim_d;
  logic              busy_q, busy_d;

  logic              emit_en, load_start;
  logic              last_bit, need_stuff;
  logic [CNT_W-1:0]  run_cnt_unused;

  run_tracker #(.RUN_LEN(RUN_LEN)) u_tracker (
    .Clock      (Clock),
    .Reset      (Reset),
    .emit_en    (emit_en),
    .emit_bit   (w_d),
    .load_start (load_start),
    .last_bit   (last_bit),
    .run_cnt    (run_cnt_unused),
    .need_stuff (need_stuff)
  );

  // Next state and the bit that state will drive, decided together so w
  // changes on the same edge as the state.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    dcnt_d     = dcnt_q;
    w_d        = 1'b0;
    emit_en    = 1'b0;
    load_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d    = SOF;
          shift_d    = in_data;
          idx_d      = '0;
          w_d        = 1'b1;
          load_start = 1'b1;
        end
      end
      SOF, DATA, STUFF: begin
        emit_en = 1'b1;
        if (need_stuff) begin
          state_d = STUFF;
          w_d     = ~last_bit;
        end else if (idx_q == IDX_W'(DATA_W)) begin
          state_d = DELIM;
          w_d     = 1'b1;
          dcnt_d  = CNT_W'(1);
        end else begin
          state_d = DATA;
          w_d     = shift_q[0];
          shift_d = shift_q >> 1;
          idx_d   = idx_q + IDX_W'(1);
        end
      end
      DELIM: begin
        if (dcnt_q == CNT_W'(RUN_LEN)) begin
          state_d = IDLE;
          dcnt_d  = '0;
          idx_d   = '0;
        end else begin
          emit_en = 1'b1;
          w_d     = 1'b1;
          dcnt_d  = dcnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    stuffing_d = (state_d == STUFF);
    delim_d    = (state_d == DELIM);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      idx_q      <= '0;
      dcnt_q     <= '0;
      w_q        <= 1'b0;
      stuffing_q <= 1'b0;
      delim_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      dcnt_q     <= dcnt_d;
      w_q        <= w_d;
      stuffing_q <= stuffing_d;
      delim_q    <= delim_d;
      busy_q     <= busy_d;
    end
  end

  assign in_ready = (state_q == IDLE);
  assign w        = w_q;
  assign stuffing = stuffing_q;
  assign delim    = delim_q;
  assign busy     = busy_q;
  assign state    = state_q;

endmodule
